// File: rtl/ibex_fetch_pkg.sv
// Shared types and helpers for the instruction fetch FIFO.
package ibex_fetch_pkg;

   localparam int unsigned FETCH_NUM_REQS   = 2;
   localparam int unsigned FETCH_FIFO_DEPTH = FETCH_NUM_REQS + 1;

   // One stored bus word with its fetch error flag.
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } fetch_entry_t;

   // RVC instructions are identified by their two lowest bits not being 2'b11.
   function automatic logic is_compressed(logic [1:0] lo_bits);
      return lo_bits != 2'b11;
   endfunction

endpackage

// File: rtl/ibex_fetch_align.sv
// Combinational instruction extraction from the two oldest FIFO words,
// selecting aligned or half-word-offset instructions by addr[1].
module ibex_fetch_align
   import ibex_fetch_pkg::*;
(
   input  logic        unaligned_i,
   input  logic        e0_valid_i,
   input  logic [31:0] e0_rdata_i,
   input  logic        e0_err_i,
   input  logic        e1_valid_i,
   input  logic [15:0] e1_rdata_lo_i,
   input  logic        e1_err_i,
   output logic [31:0] rdata_o,
   output logic        valid_o,
   output logic        err_o,
   output logic        err_plus2_o,
   output logic        compressed_o
);

   // Pick the instruction window and derive valid/error from the words it covers.
   always_comb begin
      rdata_o      = e0_rdata_i;
      valid_o      = e0_valid_i;
      err_o        = e0_err_i;
      err_plus2_o  = 1'b0;
      compressed_o = is_compressed(e0_rdata_i[1:0]);
      if (unaligned_i) begin
         compressed_o = is_compressed(e0_rdata_i[17:16]);
         rdata_o      = {e1_rdata_lo_i, e0_rdata_i[31:16]};
         // An erroring first word is presented alone so the core can redirect.
         valid_o      = e0_valid_i & (compressed_o | e1_valid_i | e0_err_i);
         err_o        = e0_err_i | (~compressed_o & e1_err_i);
         err_plus2_o  = ~e0_err_i & ~compressed_o & e1_err_i;
      end
   end

endmodule

// File: rtl/ibex_fetch_fifo.sv
// Instruction fetch FIFO: buffers bus words and presents one 16-bit aligned
// instruction per handshake with its PC and error flags.
// Optional macro IBEX_FETCH_FIFO_BYPASS_EN: when defined, an incoming word is
// presented in the same cycle if the FIFO is empty.
module ibex_fetch_fifo
   import ibex_fetch_pkg::*;
#(
   parameter int unsigned NUM_REQS = FETCH_NUM_REQS
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clear_i,
   output logic        busy_o,
   input  logic        in_valid_i,
   input  logic [31:0] in_addr_i,
   input  logic [31:0] in_rdata_i,
   input  logic        in_err_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [31:0] out_addr_o,
   output logic [31:0] out_rdata_o,
   output logic        out_err_o,
   output logic        out_err_plus2_o
);

   localparam int unsigned DEPTH = NUM_REQS + 1;

   logic [DEPTH-1:0]         valid_q, valid_d;
   fetch_entry_t [DEPTH-1:0] ent_q, ent_d;
   logic [31:0]              addr_q, addr_d;

   logic        bypass;
   logic        e0_valid;
   logic [31:0] e0_rdata;
   logic        e0_err;
   logic        compressed;
   logic        hs, pop, pop_stored, push;
   logic        placed, drop;

`ifdef IBEX_FETCH_FIFO_BYPASS_EN
   assign bypass = in_valid_i & ~valid_q[0] & ~clear_i;
`else
   assign bypass = 1'b0;
`endif

   assign e0_valid = bypass | valid_q[0];
   assign e0_rdata = bypass ? in_rdata_i : ent_q[0].rdata;
   assign e0_err   = bypass ? in_err_i   : ent_q[0].err;

   ibex_fetch_align u_align (
      .unaligned_i   (addr_q[1]),
      .e0_valid_i    (e0_valid),
      .e0_rdata_i    (e0_rdata),
      .e0_err_i      (e0_err),
      .e1_valid_i    (valid_q[1]),
      .e1_rdata_lo_i (ent_q[1].rdata[15:0]),
      .e1_err_i      (ent_q[1].err),
      .rdata_o       (out_rdata_o),
      .valid_o       (out_valid_o),
      .err_o         (out_err_o),
      .err_plus2_o   (out_err_plus2_o),
      .compressed_o  (compressed)
   );

   // An aligned compressed instruction only consumes the low half of e0.
   assign hs         = out_valid_o & out_ready_i;
   assign pop        = hs & ~(~addr_q[1] & compressed);
   assign pop_stored = pop & ~bypass;
   assign push       = in_valid_i & ~clear_i & ~(bypass & pop);

   assign busy_o     = valid_q[DEPTH-2];
   assign out_addr_o = addr_q;

   // Entry storage next state: shift on pop, then fill the lowest free slot.
   always_comb begin
      valid_d = valid_q;
      ent_d   = ent_q;
      placed  = 1'b0;
      drop    = 1'b0;
      if (pop_stored) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            valid_d[i] = valid_q[i+1];
            ent_d[i]   = ent_q[i+1];
         end
         valid_d[DEPTH-1] = 1'b0;
      end
      if (push) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (!placed && !valid_d[i]) begin
               valid_d[i]     = 1'b1;
               ent_d[i].rdata = in_rdata_i;
               ent_d[i].err   = in_err_i;
               placed         = 1'b1;
            end
         end
         drop = ~placed;
      end
      if (clear_i) valid_d = '0;
   end

   // Fetch PC: reload on clear, otherwise advance by the consumed size.
   always_comb begin
      addr_d = addr_q;
      if (clear_i)  addr_d = {in_addr_i[31:1], 1'b0};
      else if (hs)  addr_d = addr_q + (compressed ? 32'd2 : 32'd4);
   end

   // State registers; a push into a full FIFO with no pop is a protocol error.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         ent_q   <= '0;
         addr_q  <= '0;
      end else begin
         assert (!drop);
         valid_q <= valid_d;
         ent_q   <= ent_d;
         addr_q  <= addr_d;
      end
   end

endmodule

// File: tb/tb_ibex_fetch_fifo.sv
module tb_ibex_fetch_fifo;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic        busy;
   logic        in_valid;
   logic [31:0] in_addr;
   logic [31:0] in_rdata;
   logic        in_err;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_addr;
   logic [31:0] out_rdata;
   logic        out_err;
   logic        out_err_plus2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ibex_fetch_fifo dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .clear_i         (clear),
      .busy_o          (busy),
      .in_valid_i      (in_valid),
      .in_addr_i       (in_addr),
      .in_rdata_i      (in_rdata),
      .in_err_i        (in_err),
      .out_valid_o     (out_valid),
      .out_ready_i     (out_ready),
      .out_addr_o      (out_addr),
      .out_rdata_o     (out_rdata),
      .out_err_o       (out_err),
      .out_err_plus2_o (out_err_plus2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_err    = 1'b0;
      out_ready = 1'b0;
   endtask

   task automatic do_clear(input logic [31:0] a);
      clear   = 1'b1;
      in_addr = a;
      tick();
   endtask

   task automatic do_push(input logic [31:0] d, input logic e);
      in_valid = 1'b1;
      in_rdata = d;
      in_err   = e;
      tick();
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_addr = '0;
      in_rdata = '0; in_err = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy",  {31'd0, busy}, 32'd0);
      chk("rst_err",   {31'd0, out_err}, 32'd0);
      chk("rst_plus2", {31'd0, out_err_plus2}, 32'd0);
      chk("rst_addr",  out_addr, 32'd0);
      rst = 1'b0;
      tick();

      // aligned uncompressed
      do_clear(32'h80);
      chk("clr_valid", {31'd0, out_valid}, 32'd0);
      chk("clr_addr",  out_addr, 32'h80);
      do_push(32'h0000_0013, 1'b0);
      chk("al_valid", {31'd0, out_valid}, 32'd1);
      chk("al_addr",  out_addr, 32'h80);
      chk("al_rdata", out_rdata, 32'h0000_0013);
      chk("al_err",   {31'd0, out_err}, 32'd0);
      out_ready = 1'b1; tick();
      chk("al_empty", {31'd0, out_valid}, 32'd0);
      chk("al_addr2", out_addr, 32'h84);

      // two compressed in one word
      do_push(32'h4581_4501, 1'b0);
      chk("c0_valid", {31'd0, out_valid}, 32'd1);
      chk("c0_rdata", {16'd0, out_rdata[15:0]}, 32'h4501);
      out_ready = 1'b1; tick();
      chk("c1_valid", {31'd0, out_valid}, 32'd1);
      chk("c1_addr",  out_addr, 32'h86);
      chk("c1_rdata", {16'd0, out_rdata[15:0]}, 32'h4581);
      out_ready = 1'b1; tick();
      chk("c_empty",  {31'd0, out_valid}, 32'd0);
      chk("c_addr",   out_addr, 32'h88);

      // straddling
      do_clear(32'h82);
      do_push(32'h0013_0000, 1'b0);
      chk("st_wait",  {31'd0, out_valid}, 32'd0);
      chk("st_busy0", {31'd0, busy}, 32'd0);
      do_push(32'h0000_0000, 1'b0);
      chk("st_valid", {31'd0, out_valid}, 32'd1);
      chk("st_rdata", out_rdata, 32'h0000_0013);
      chk("st_addr",  out_addr, 32'h82);
      chk("st_busy1", {31'd0, busy}, 32'd1);
      out_ready = 1'b1; tick();
      chk("st_addr2", out_addr, 32'h86);
      chk("st_cval",  {31'd0, out_valid}, 32'd1);
      chk("st_crd",   {16'd0, out_rdata[15:0]}, 32'h0);
      out_ready = 1'b1; tick();
      chk("st_empty", {31'd0, out_valid}, 32'd0);
      chk("st_addr3", out_addr, 32'h88);

      // error in second half only
      do_clear(32'h82);
      do_push(32'hFFFF_0000, 1'b0);
      chk("p2_wait",  {31'd0, out_valid}, 32'd0);
      do_push(32'h1234_5678, 1'b1);
      chk("p2_valid", {31'd0, out_valid}, 32'd1);
      chk("p2_rdata", out_rdata, 32'h5678_FFFF);
      chk("p2_err",   {31'd0, out_err}, 32'd1);
      chk("p2_plus2", {31'd0, out_err_plus2}, 32'd1);

      // erroring first word presented without its successor
      do_clear(32'h82);
      do_push(32'hFFFF_0000, 1'b1);
      chk("e0_valid", {31'd0, out_valid}, 32'd1);
      chk("e0_err",   {31'd0, out_err}, 32'd1);
      chk("e0_plus2", {31'd0, out_err_plus2}, 32'd0);

      // flush mid-stream
      do_clear(32'h0);
      do_push(32'h0010_0093, 1'b0);
      chk("fl_busy0", {31'd0, busy}, 32'd0);
      do_push(32'h0020_0113, 1'b0);
      chk("fl_busy1", {31'd0, busy}, 32'd1);
      do_push(32'h0030_0193, 1'b0);
      chk("fl_rdata", out_rdata, 32'h0010_0093);
      clear = 1'b1; in_addr = 32'h1000; in_valid = 1'b1;
      in_rdata = 32'h0040_0213; out_ready = 1'b1;
      tick();
      chk("fl_valid", {31'd0, out_valid}, 32'd0);
      chk("fl_busy",  {31'd0, busy}, 32'd0);
      chk("fl_addr",  out_addr, 32'h1000);
      tick();
      chk("fl_drop",  {31'd0, out_valid}, 32'd0);

      // full-throughput backpressure
      do_clear(32'h2000);
      do_push(32'h0010_0093, 1'b0);
      do_push(32'h0020_0113, 1'b0);
      chk("bp_busy",  {31'd0, busy}, 32'd1);
      do_push(32'h0030_0193, 1'b0);
      chk("bp_head",  out_rdata, 32'h0010_0093);
      in_valid = 1'b1; in_rdata = 32'h0040_0213; out_ready = 1'b1; tick();
      chk("bp_b",     out_rdata, 32'h0020_0113);
      chk("bp_baddr", out_addr, 32'h2004);
      chk("bp_full",  {31'd0, busy}, 32'd1);
      in_valid = 1'b1; in_rdata = 32'h0050_0293; out_ready = 1'b1; tick();
      chk("bp_c",     out_rdata, 32'h0030_0193);
      chk("bp_caddr", out_addr, 32'h2008);
      out_ready = 1'b1; tick();
      chk("bp_d",     out_rdata, 32'h0040_0213);
      chk("bp_daddr", out_addr, 32'h200C);
      out_ready = 1'b1; tick();
      chk("bp_e",     out_rdata, 32'h0050_0293);
      chk("bp_eaddr", out_addr, 32'h2010);
      chk("bp_ebusy", {31'd0, busy}, 32'd0);
      out_ready = 1'b1; tick();
      chk("bp_empty", {31'd0, out_valid}, 32'd0);
      chk("bp_addr",  out_addr, 32'h2014);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
